imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-port controller that owns the single-ported 32x32 instruction/data memory (`imemory`) and shares it between the fetch stage (port A, read-only) and the program loader / data port (port B, read/write). After reset it clears the memory with a 32-cycle zero-fill sweep. It then grants one access per cycle using round-robin arbitration. It drives the memory's `addr`/`d_in`/`rd`/`wr` from registers and returns read data with fixed latency.

## Interface
- `AW`, 5, address width (memory depth = 2^AW)
- `DW`, 32, data width
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `a_req`  in  1  fetch request; held with `a_addr` until granted
- `a_addr`  in  AW  fetch address
- `a_gnt`  out  1  combinational grant, one cycle per accepted request
- `a_rvalid`  out  1  one-cycle pulse, `a_rdata` valid
- `a_rdata`  out  DW  registered read data
- `b_req`  in  1  loader/data request; held with `b_we`, `b_addr`, `b_wdata` until granted
- `b_we`  in  1  1 = write, 0 = read
- `b_addr`  in  AW  address
- `b_wdata`  in  DW  write data
- `b_gnt`  out  1  combinational grant
- `b_rvalid`  out  1  one-cycle pulse on read completion only
- `b_rdata`  out  DW  registered read data
- `mem_addr`  out  AW  registered, to memory `addr`
- `mem_din`  out  DW  registered, to memory `d_in`
- `mem_rd`  out  1  registered, to memory `rd`
- `mem_wr`  out  1  registered, to memory `wr`
- `mem_dout`  in  DW  from memory `d_out` (combinational read)
- `init_done`  out  1  high once the zero-fill sweep completes

## Operation
- States: INIT, IDLE, ACCESS.
  - INIT: clearing sweep.
  - IDLE: no command is driven to the memory.
  - ACCESS: the command register holds one access being driven to the memory.
- INIT behaviour:
  - Counter `cnt` (AW bits) steps 0..31.
  - Each cycle the registers drive `mem_wr`=1, `mem_rd`=0, `mem_addr`=`cnt`, `mem_din`=0.
  - Both grants are 0.
  - At the edge where `cnt`==31 is being written: state becomes IDLE and `init_done` becomes 1.
- Arbitration (in IDLE or ACCESS):
  - Only one requester: that requester is granted.
  - Both request: the port not granted last is granted.
  - The round-robin pointer resets to "last = B", so A wins the first tie.
  - At most one grant per cycle; grant is combinational from `req` and state.
- On grant, at the edge:
  - The command register loads addr, data and direction, plus an owner tag.
  - State becomes ACCESS.
  - The pointer is updated.
- Port A is never a write: `mem_wr` = `b_we` only for a port-B command.
- Transitions:
  - ACCESS -> ACCESS on a new grant.
  - ACCESS -> IDLE with no grant; in IDLE `mem_rd`=`mem_wr`=0 and `mem_addr`/`mem_din` hold their values.
- Invariant: `mem_rd` and `mem_wr` are never both 1.
- Read completion: at the edge ending an ACCESS read cycle, `mem_dout` is captured into the owner's `rdata` and the owner's `rvalid` pulses for the next cycle. The other port's `rdata` is unchanged.
- Writes produce no `rvalid`.

## Timing
- Reset, at the edge with `reset`=1:
  - State INIT, `cnt`=0, pointer = B, `init_done`=0.
  - `a_rvalid`=`b_rvalid`=0 and `a_rdata`=`b_rdata`=0.
  - `mem_rd`=`mem_wr`=0, `mem_addr`=0, `mem_din`=0; grants are 0.
- INIT lasts exactly 32 cycles after reset deasserts. First grant is possible in cycle 33.
- Read latency and throughput:
  - Grant in cycle N; memory driven in N+1; `rvalid`/`rdata` in N+2.
  - Throughput is one access per cycle, back-to-back across ports.
- A write granted in N is applied to the memory in N+1. A read of the same address granted in N+1 returns the new data.
- Requests asserted during INIT wait (no grant). They are granted in the first IDLE cycle, with the tie rule applied.
- Reset mid-operation:
  - An in-flight command is dropped and no `rvalid` fires.
  - Any pending `rvalid` is cleared.
  - The FSM re-enters INIT and the memory is re-cleared.

## Test plan
- **Reset / init sweep:** `reset` 1 cycle, then 0.
  - `mem_wr`=1 for exactly 32 cycles, `mem_addr` 0..31, `mem_din`=0.
  - `init_done` rises after addr 31; grants are 0 throughout.
- **B write then A read, same address:**
  - B writes 0xDEADBEEF to addr 7 (granted cycle N).
  - A reads addr 7 (granted N+1).
  - `a_rvalid` in N+3 with `a_rdata`=0xDEADBEEF; no `b_rvalid`.
- **Simultaneous requests, held continuously:** A (addr 1) and B reads (addr 2).
  - Grants alternate A,B,A,B starting with A.
  - One `rvalid` per cycle from N+2.
- **Read of unwritten location after init:** A reads addr 31 -> `a_rdata`=0.
- **Reset mid-read:** A granted in N, `reset` in N+1.
  - No `a_rvalid` in N+2.
  - INIT restarts at `cnt`=0 and a previously written location reads 0 afterwards.
- **Request during INIT:** `a_req` is high from reset release.
  - `a_gnt` first asserts in cycle 33.
  - `mem_rd`/`mem_wr` are never simultaneously 1 at any point.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: zero-fills a single-ported memory after reset, then shares it
// between a read-only fetch port and a read/write loader port, round-robin.
module imem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_dout,
    output logic          init_done
);
    typedef enum logic [1:0] {INIT, IDLE, ACCESS} state_t;
    state_t state, state_nxt;
    logic [AW-1:0] cnt;
    logic last_b, owner_b, rd_done;
    always_comb begin
        a_gnt = (state != INIT) && a_req && (!b_req || last_b);
        b_gnt = (state != INIT) && b_req && !a_gnt;
        state_nxt = (state == INIT) ? (&cnt ? IDLE : INIT) : ((a_gnt || b_gnt) ? ACCESS : IDLE);
        rd_done = (state == ACCESS) && mem_rd;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= '0;
            last_b    <= 1'b1;
            owner_b   <= 1'b0;
            init_done <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_rvalid <= rd_done && !owner_b;
            b_rvalid <= rd_done && owner_b;
            if (rd_done && !owner_b) a_rdata <= mem_dout;
            if (rd_done && owner_b) b_rdata <= mem_dout;
            // sweep writes the address the counter holds, so addr 31 lands on the last INIT edge
            if (state == INIT) begin
                cnt      <= cnt + AW'(1);
                mem_addr <= cnt;
                mem_din  <= '0;
                mem_wr   <= 1'b1;
                mem_rd   <= 1'b0;
                if (&cnt) init_done <= 1'b1;
            end else if (a_gnt) begin
                mem_addr <= a_addr;
                mem_rd   <= 1'b1;
                mem_wr   <= 1'b0;
                owner_b  <= 1'b0;
                last_b   <= 1'b0;
            end else if (b_gnt) begin
                mem_addr <= b_addr;
                mem_din  <= b_wdata;
                mem_rd   <= !b_we;
                mem_wr   <= b_we;
                owner_b  <= 1'b1;
                last_b   <= 1'b1;
            end else begin
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vectors plus reset/init sequences against a
// behavioural 32x32 memory preloaded with non-zero contents.
module tb_imem_arbiter;
    logic clk = 0, reset;
    logic a_req, a_gnt, a_rvalid, b_req, b_we, b_gnt, b_rvalid, mem_rd, mem_wr, init_done;
    logic [4:0] a_addr, b_addr, mem_addr;
    logic [31:0] a_rdata, b_wdata, b_rdata, mem_din, mem_dout;
    logic [31:0] mem [32];
    int checks = 0, errors = 0;

    imem_arbiter #(.AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .init_done(init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_din;
    assign mem_dout = mem[mem_addr];

    typedef struct {
        logic ar; logic [4:0] aa; logic br, bw; logic [4:0] ba; logic [31:0] bd;
        logic eag, ebg, earv, ebrv; logic [31:0] eard, ebrd;
    } vec_t;
    vec_t tv [15];

    function automatic vec_t mk(input logic ar, input logic [4:0] aa, input logic br, input logic bw,
                                input logic [4:0] ba, input logic [31:0] bd, input logic eag, input logic ebg,
                                input logic earv, input logic ebrv, input logic [31:0] eard, input logic [31:0] ebrd);
        mk = '{ar, aa, br, bw, ba, bd, eag, ebg, earv, ebrv, eard, ebrd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rd/wr exclusivity, sampled away from the edge every cycle
    always @(negedge clk) begin
        checks++;
        if (mem_rd && mem_wr) begin
            errors++;
            $display("FAIL rd_wr_exclusive: got rd=1 wr=1 expected not both at %0t", $time);
        end
    end

    task automatic reset_state_checks();
        chk("rst_init_done", init_done, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
    endtask

    task automatic init_sweep(input logic a_pending);
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("sweep_wr", mem_wr, 1);
            chk("sweep_rd", mem_rd, 0);
            chk("sweep_addr", mem_addr, 32'(k - 1));
            chk("sweep_din", mem_din, 0);
            chk("sweep_done", init_done, (k == 32) ? 1 : 0);
            chk("sweep_a_gnt", a_gnt, (a_pending && k == 32) ? 1 : 0);
            chk("sweep_b_gnt", b_gnt, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | i;
        tv[0]  = mk(0, 0, 1, 1, 1, 32'h1111_1111, 0, 1, 0, 0, 32'h0, 32'h0);
        tv[1]  = mk(0, 0, 1, 1, 2, 32'h2222_2222, 0, 1, 1, 0, 32'h0, 32'h0);
        tv[2]  = mk(0, 0, 1, 1, 7, 32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0, 32'h0);
        tv[3]  = mk(1, 7, 0, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0, 32'h0);
        tv[4]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0, 32'h0);
        tv[5]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'hDEAD_BEEF, 32'h0);
        tv[6]  = mk(0, 0, 1, 0, 7, 32'h0,         0, 1, 0, 0, 32'hDEAD_BEEF, 32'h0);
        tv[7]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0);
        tv[8]  = mk(1, 1, 1, 0, 2, 32'h0,         1, 0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tv[9]  = mk(1, 1, 1, 0, 2, 32'h0,         0, 1, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tv[10] = mk(1, 1, 1, 0, 2, 32'h0,         1, 0, 1, 0, 32'h1111_1111, 32'hDEAD_BEEF);
        tv[11] = mk(1, 1, 1, 0, 2, 32'h0,         0, 1, 0, 1, 32'h1111_1111, 32'h2222_2222);
        tv[12] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h1111_1111, 32'h2222_2222);
        tv[13] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h1111_1111, 32'h2222_2222);
        tv[14] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h1111_1111, 32'h2222_2222);
        reset = 1; a_req = 1; a_addr = 31; b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        reset_state_checks();
        init_sweep(1);
        tick();
        chk("fetch31_rd", mem_rd, 1);
        chk("fetch31_addr", mem_addr, 31);
        for (int i = 0; i < 15; i++) begin
            a_req = tv[i].ar; a_addr = tv[i].aa;
            b_req = tv[i].br; b_we = tv[i].bw; b_addr = tv[i].ba; b_wdata = tv[i].bd;
            #1;
            chk($sformatf("v%0d_a_gnt", i), a_gnt, tv[i].eag);
            chk($sformatf("v%0d_b_gnt", i), b_gnt, tv[i].ebg);
            chk($sformatf("v%0d_a_rvalid", i), a_rvalid, tv[i].earv);
            chk($sformatf("v%0d_b_rvalid", i), b_rvalid, tv[i].ebrv);
            chk($sformatf("v%0d_a_rdata", i), a_rdata, tv[i].eard);
            chk($sformatf("v%0d_b_rdata", i), b_rdata, tv[i].ebrd);
            tick();
        end
        a_req = 1; a_addr = 7;
        #1 chk("midrst_a_gnt", a_gnt, 1);
        tick();
        a_req = 0; reset = 1;
        chk("midrst_mem_rd", mem_rd, 1);
        chk("midrst_mem_addr", mem_addr, 7);
        tick();
        reset = 0;
        reset_state_checks();
        init_sweep(0);
        a_req = 1; a_addr = 7;
        #1 chk("reinit_a_gnt", a_gnt, 1);
        tick();
        a_req = 0;
        chk("reinit_no_rvalid", a_rvalid, 0);
        tick();
        chk("reinit_a_rvalid", a_rvalid, 1);
        chk("reinit_a_rdata", a_rdata, 0);
        tick();
        chk("reinit_rvalid_pulse", a_rvalid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
